// File: rtl/reservation_station_pkg.sv
// Shared sizing defaults and the register-0 "no register" convention used by
// issue, the reservation station and the scoreboard.
package reservation_station_pkg;

  localparam int RS_NUM_REG    = 8;
  localparam int RS_OP_BIT     = 4;
  localparam int RS_REG_ID_BIT = $clog2(RS_NUM_REG);

  // Physical register id meaning "no source / no destination".
  localparam int REG_NONE = 0;

endpackage

// File: rtl/reservation_station_decode.sv
// Binary register id to one-hot decoder.
module decode #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  idx_i,
  output logic [OUT_W-1:0] onehot_o
);

  assign onehot_o = OUT_W'(1) << idx_i;

endmodule

// File: rtl/reservation_station.sv
// Per-FU in-order reservation station: circular queue of renamed operations
// feeding the scoreboard read port, plus a read-pending bitmap of queued sources.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int NUM_REG    = RS_NUM_REG,
  parameter int NUM_ENTRY  = 4,
  parameter int OP_BIT     = RS_OP_BIT,
  parameter int REG_ID_BIT = $clog2(NUM_REG),
  parameter int PTR_BIT    = $clog2(NUM_ENTRY)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [OP_BIT-1:0]     in_op,
  input  logic [REG_ID_BIT-1:0] in_dst_reg,
  input  logic [REG_ID_BIT-1:0] in_src_reg0,
  input  logic [REG_ID_BIT-1:0] in_src_reg1,
  output logic                  fu_available,
  output logic [NUM_REG-1:0]    reg_read_pending,
  output logic                  rd_vld,
  input  logic                  rd_rdy,
  output logic [REG_ID_BIT-1:0] rd_reg0_id,
  output logic [REG_ID_BIT-1:0] rd_reg1_id,
  output logic [REG_ID_BIT-1:0] rd_write_reg_id_nxt,
  output logic [OP_BIT-1:0]     rd_op,
  output logic [PTR_BIT:0]      count
);

  localparam logic [PTR_BIT:0]   FULL_CNT  = (PTR_BIT+1)'(NUM_ENTRY);
  localparam logic [NUM_REG-1:0] PEND_MASK = ~(NUM_REG'(1) << REG_NONE);

  logic [PTR_BIT-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_BIT-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_BIT:0]      count_q, count_d;
  logic                  full, empty, enq, deq;

  logic [OP_BIT-1:0]     op_q   [NUM_ENTRY];
  logic [REG_ID_BIT-1:0] dst_q  [NUM_ENTRY];
  logic [REG_ID_BIT-1:0] src0_q [NUM_ENTRY];
  logic [REG_ID_BIT-1:0] src1_q [NUM_ENTRY];

  logic [NUM_ENTRY-1:0]  ent_vld;
  logic [NUM_REG-1:0]    pend_ent [NUM_ENTRY];

  // Status is a function of registered count only, so rd_rdy never reaches in_rdy.
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign in_rdy       = !full;
  assign fu_available = !full;
  assign rd_vld       = !empty;
  assign count        = count_q;

  assign enq = in_vld && !full;
  assign deq = !empty && rd_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is never reset; validity comes from the rd_ptr/count window.
  always_ff @(posedge clk) begin
    if (enq) begin
      op_q[wr_ptr_q]   <= in_op;
      dst_q[wr_ptr_q]  <= in_dst_reg;
      src0_q[wr_ptr_q] <= in_src_reg0;
      src1_q[wr_ptr_q] <= in_src_reg1;
    end
  end

  always_comb begin
    rd_op               = '0;
    rd_write_reg_id_nxt = '0;
    rd_reg0_id          = '0;
    rd_reg1_id          = '0;
    if (!empty) begin
      rd_op               = op_q[rd_ptr_q];
      rd_write_reg_id_nxt = dst_q[rd_ptr_q];
      rd_reg0_id          = src0_q[rd_ptr_q];
      rd_reg1_id          = src1_q[rd_ptr_q];
    end
  end

  for (genvar g = 0; g < NUM_ENTRY; g++) begin : g_ent
    logic [PTR_BIT-1:0] off;
    logic [NUM_REG-1:0] s0_oh, s1_oh;

    // Distance from the head; the entry is live when it lies inside [0, count).
    assign off        = PTR_BIT'(g) - rd_ptr_q;
    assign ent_vld[g] = ({1'b0, off} < count_q);

    decode #(.IN_W(REG_ID_BIT), .OUT_W(NUM_REG)) u_dec_src0 (
      .idx_i    (src0_q[g]),
      .onehot_o (s0_oh)
    );

    decode #(.IN_W(REG_ID_BIT), .OUT_W(NUM_REG)) u_dec_src1 (
      .idx_i    (src1_q[g]),
      .onehot_o (s1_oh)
    );

    assign pend_ent[g] = (s0_oh | s1_oh) & {NUM_REG{ent_vld[g]}} & PEND_MASK;
  end

  always_comb begin
    reg_read_pending = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      reg_read_pending = reg_read_pending | pend_ent[i];
    end
  end

endmodule
